// File: rtl/paddle_key_controller.sv
// Paddle key controller: turns the four raw board keys into a horizontal
// paddle position that moves at most once per video frame.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE       | no direction key held, or both held; position holds
//   MOVE_LEFT  | left held alone; position steps down once per frame
//   MOVE_RIGHT | right held alone; position steps up once per frame
//
// Timing: vsync is synchronised and edge-detected into a one-cycle tick.
// The debounced keys update on the tick cycle. All control (pause, centre,
// FSM, movement, acceleration) acts one cycle later on the registered tick,
// so it always sees the freshly debounced keys.
module paddle_key_controller #(
    parameter int POS_WIDTH       = 8,
    parameter int POS_MIN         = 0,
    parameter int POS_MAX         = 224,
    parameter int POS_INIT        = 112,
    parameter int SPEED_WIDTH     = 3,
    parameter int SPEED_MIN       = 1,
    parameter int SPEED_MAX       = 4,
    parameter int ACCEL_FRAMES    = 8,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [3:0]             keys_i,
    input  logic                   vsync_i,
    output logic [POS_WIDTH-1:0]   hpaddle_o,
    output logic [SPEED_WIDTH-1:0] speed_o,
    output logic                   moving_o,
    output logic                   paused_o
);

    localparam int DB_W   = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;
    localparam int HOLD_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam int PW1    = POS_WIDTH + 1;

    localparam logic [POS_WIDTH-1:0]   P_MIN   = POS_WIDTH'(POS_MIN);
    localparam logic [POS_WIDTH-1:0]   P_MAX   = POS_WIDTH'(POS_MAX);
    localparam logic [POS_WIDTH-1:0]   P_INIT  = POS_WIDTH'(POS_INIT);
    localparam logic [SPEED_WIDTH-1:0] S_MIN   = SPEED_WIDTH'(SPEED_MIN);
    localparam logic [SPEED_WIDTH-1:0] S_MAX   = SPEED_WIDTH'(SPEED_MAX);
    localparam logic [HOLD_W-1:0]      H_LAST  = HOLD_W'(ACCEL_FRAMES - 1);
    localparam logic [DB_W-1:0]        DB_LAST = DB_W'(DEBOUNCE_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MOVE_LEFT  = 2'd1,
        MOVE_RIGHT = 2'd2
    } state_t;

    // Synchronisers and frame-edge detect
    logic [3:0] keys_s1_q, keys_s2_q;
    logic       vs_s1_q, vs_s2_q, vs_prev_q;
    logic       tick;
    logic       tick_q;

    // Debounce
    logic [3:0]      deb_q, deb_d;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];

    // Control
    state_t                 state_q, state_d;
    logic [POS_WIDTH-1:0]   pos_q, pos_d;
    logic [SPEED_WIDTH-1:0] speed_q, speed_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   paused_q, paused_d;
    logic                   moving_q, moving_d;
    logic [3:0]             deb_prev_q, deb_prev_d;

    logic                   key_l, key_r;
    logic                   pause_rise, centre_rise;
    logic                   reversal;
    logic [SPEED_WIDTH-1:0] step;
    logic [PW1-1:0]         pos_ext, step_ext, sum_ext;

    assign tick        = vs_s2_q & ~vs_prev_q;
    assign key_l       = deb_q[0] & ~deb_q[1];
    assign key_r       = deb_q[1] & ~deb_q[0];
    assign pause_rise  = deb_q[3] & ~deb_prev_q[3];
    assign centre_rise = deb_q[2] & ~deb_prev_q[2];

    // Synchronise keys and vsync into this clock domain; register the tick
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            keys_s1_q <= '0;
            keys_s2_q <= '0;
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            vs_prev_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            keys_s1_q <= keys_i;
            keys_s2_q <= keys_s1_q;
            vs_s1_q   <= vsync_i;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
            tick_q    <= tick;
        end
    end

    // Per-key frame-rate debounce: flip only after enough consecutive differing samples
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (tick) begin
                if (keys_s2_q[i] == deb_q[i]) begin
                    db_cnt_d[i] = '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i]    = ~deb_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            deb_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // Next-state, movement, clamping and acceleration, evaluated on the registered tick
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        speed_d    = speed_q;
        hold_d     = hold_q;
        paused_d   = paused_q;
        deb_prev_d = deb_prev_q;
        reversal   = 1'b0;
        step       = speed_q;
        pos_ext    = '0;
        step_ext   = '0;
        sum_ext    = '0;

        if (tick_q) begin
            deb_prev_d = deb_q;
            if (pause_rise) paused_d = ~paused_q;

            if (pause_rise && !paused_q) begin
                state_d = IDLE;
                speed_d = S_MIN;
                hold_d  = '0;
            end else if (!paused_d) begin
                if (centre_rise) begin
                    pos_d   = P_INIT;
                    state_d = IDLE;
                    speed_d = S_MIN;
                    hold_d  = '0;
                end else begin
                    case (state_q)
                        IDLE:       state_d = key_l ? MOVE_LEFT : (key_r ? MOVE_RIGHT : IDLE);
                        MOVE_LEFT:  state_d = key_l ? MOVE_LEFT : (key_r ? MOVE_RIGHT : IDLE);
                        MOVE_RIGHT: state_d = key_r ? MOVE_RIGHT : (key_l ? MOVE_LEFT : IDLE);
                        default:    state_d = IDLE;
                    endcase

                    // A reversal restarts from the minimum step on this very tick
                    reversal = (state_q != IDLE) && (state_d != IDLE) && (state_d != state_q);
                    step     = reversal ? S_MIN : speed_q;

                    pos_ext                    = {1'b0, pos_q};
                    step_ext[SPEED_WIDTH-1:0]  = step;

                    if (state_d == MOVE_LEFT) begin
                        if (pos_ext < step_ext + PW1'(POS_MIN)) pos_d = P_MIN;
                        else                                    pos_d = pos_q - POS_WIDTH'(step);
                    end else if (state_d == MOVE_RIGHT) begin
                        sum_ext = pos_ext + step_ext;
                        if (sum_ext > PW1'(POS_MAX)) pos_d = P_MAX;
                        else                         pos_d = sum_ext[POS_WIDTH-1:0];
                    end

                    if (state_d == IDLE || reversal) begin
                        speed_d = S_MIN;
                        hold_d  = '0;
                    end else if (hold_q == H_LAST) begin
                        speed_d = (speed_q >= S_MAX) ? S_MAX : speed_q + SPEED_WIDTH'(1);
                        hold_d  = '0;
                    end else begin
                        hold_d  = hold_q + HOLD_W'(1);
                    end
                end
            end
        end

        moving_d = (state_d != IDLE);
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            pos_q      <= P_INIT;
            speed_q    <= S_MIN;
            hold_q     <= '0;
            paused_q   <= 1'b0;
            moving_q   <= 1'b0;
            deb_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            speed_q    <= speed_d;
            hold_q     <= hold_d;
            paused_q   <= paused_d;
            moving_q   <= moving_d;
            deb_prev_q <= deb_prev_d;
        end
    end

    assign hpaddle_o = pos_q;
    assign speed_o   = speed_q;
    assign moving_o  = moving_q;
    assign paused_o  = paused_q;

endmodule

// File: tb/tb_paddle_key_controller.sv
// Scoreboard bench for paddle_key_controller: each frame pushes its expected
// outputs, a monitor pops and compares them once the frame strobe falls.
module tb_paddle_key_controller;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic [3:0] keys_i;
    logic       vsync_i = 1'b0;
    logic [7:0] hpaddle_o;
    logic [2:0] speed_o;
    logic       moving_o;
    logic       paused_o;

    paddle_key_controller dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .keys_i    (keys_i),
        .vsync_i   (vsync_i),
        .hpaddle_o (hpaddle_o),
        .speed_o   (speed_o),
        .moving_o  (moving_o),
        .paused_o  (paused_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int    pos;
        int    spd;
        int    mov;
        int    pau;
        string tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input int pos, input int spd, input int mov, input int pau);
        check({tag, ".hpaddle"}, 32'(hpaddle_o), pos);
        check({tag, ".speed"},   32'(speed_o),   spd);
        check({tag, ".moving"},  32'(moving_o),  mov);
        check({tag, ".paused"},  32'(paused_o),  pau);
    endtask

    task automatic push(input int pos, input int spd, input int mov, input int pau, input string tag);
        exp_t e;
        e.pos = pos; e.spd = spd; e.mov = mov; e.pau = pau; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic frame(input int pos, input int spd, input int mov, input int pau, input string tag);
        push(pos, spd, mov, pau, tag);
        repeat (4) @(negedge clk_i);
        vsync_i = 1'b1;
        repeat (6) @(negedge clk_i);
        vsync_i = 1'b0;
        repeat (6) @(negedge clk_i);
    endtask

    // Monitor: outputs have settled by the time the frame strobe falls
    initial begin
        exp_t e;
        #1;
        forever begin
            @(negedge vsync_i);
            @(negedge clk_i);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: got a frame with no expected entry (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                check_out(e.tag, e.pos, e.spd, e.mov, e.pau);
            end
        end
    end

    initial begin
        int p;
        reset_ni = 1'b0;
        keys_i   = 4'b0000;
        repeat (3) @(negedge clk_i);
        check_out("reset", 112, 1, 0, 0);
        reset_ni = 1'b1;
        repeat (3) @(negedge clk_i);

        for (int f = 0; f < 5; f++) frame(112, 1, 0, 0, "idle");

        // Hold left: one debounce frame, then 8 frames at speed 1, then speed 2
        keys_i = 4'b0001;
        frame(112, 1, 0, 0, "left_deb");
        for (int f = 2; f <= 12; f++)
            frame((f <= 9) ? 113 - f : 104 - 2 * (f - 9), (f >= 9) ? 2 : 1, 1, 0, "left_hold");

        // Swap left for right: flip takes effect after debounce with step 1
        keys_i = 4'b0010;
        frame(96, 2, 1, 0, "rev_pend");
        frame(97, 1, 1, 0, "rev_flip");
        frame(98, 1, 1, 0, "rev_step");
        keys_i = 4'b0011;
        frame(99, 1, 1, 0, "both_pend");
        frame(99, 1, 0, 0, "both_idle");
        frame(99, 1, 0, 0, "both_hold");
        keys_i = 4'b0000;
        frame(99, 1, 0, 0, "release");
        frame(99, 1, 0, 0, "release");

        // Single-frame glitches on right, separated so the counter must clear
        keys_i = 4'b0010;
        frame(99, 1, 0, 0, "glitch1");
        keys_i = 4'b0000;
        frame(99, 1, 0, 0, "glitch1_gone");
        frame(99, 1, 0, 0, "glitch1_gone");
        keys_i = 4'b0010;
        frame(99, 1, 0, 0, "glitch2");
        keys_i = 4'b0000;
        frame(99, 1, 0, 0, "glitch2_gone");
        frame(99, 1, 0, 0, "glitch2_gone");

        // Hold right to the edge: reaches 223 on move frame 43, then clamps at 224
        keys_i = 4'b0010;
        frame(99, 1, 0, 0, "right_deb");
        for (int n = 1; n <= 46; n++) begin
            if (n <= 8)       p = 99 + n;
            else if (n <= 16) p = 107 + 2 * (n - 8);
            else if (n <= 24) p = 123 + 3 * (n - 16);
            else              p = 147 + 4 * (n - 24);
            if (p > 224) p = 224;
            frame(p, (n < 8) ? 1 : (n < 16) ? 2 : (n < 24) ? 3 : 4, 1, 0, "right_run");
        end

        // Pause while clamped and moving, centre ignored while paused
        keys_i = 4'b1010;
        frame(224, 4, 1, 0, "pause_pend");
        frame(224, 1, 0, 1, "pause_on");
        frame(224, 1, 0, 1, "pause_frozen");
        keys_i = 4'b1110;
        frame(224, 1, 0, 1, "centre_paused");
        frame(224, 1, 0, 1, "centre_paused");
        frame(224, 1, 0, 1, "centre_paused");
        keys_i = 4'b0010;
        frame(224, 1, 0, 1, "pause_rel");
        frame(224, 1, 0, 1, "pause_rel");
        keys_i = 4'b1000;
        frame(224, 1, 0, 1, "unpause_pend");
        frame(224, 1, 0, 0, "unpause");
        keys_i = 4'b0000;
        frame(224, 1, 0, 0, "unpause_rel");
        frame(224, 1, 0, 0, "unpause_rel");
        keys_i = 4'b0100;
        frame(224, 1, 0, 0, "centre_pend");
        frame(112, 1, 0, 0, "centre");
        keys_i = 4'b0000;
        frame(112, 1, 0, 0, "centre_rel");
        frame(112, 1, 0, 0, "centre_rel");

        // Accelerated left move, then a one-cycle reset in the middle of a frame
        keys_i = 4'b0001;
        frame(112, 1, 0, 0, "accel_deb");
        for (int n = 1; n <= 9; n++)
            frame((n <= 8) ? 112 - n : 104 - 2 * (n - 8), (n >= 8) ? 2 : 1, 1, 0, "accel_run");
        repeat (4) @(negedge clk_i);
        vsync_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b0;
        keys_i   = 4'b0000;
        #1;
        check_out("async_reset", 112, 1, 0, 0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        push(112, 1, 0, 0, "post_reset");
        repeat (4) @(negedge clk_i);
        vsync_i = 1'b0;
        repeat (6) @(negedge clk_i);
        frame(112, 1, 0, 0, "post_reset_idle");
        frame(112, 1, 0, 0, "post_reset_idle");

        repeat (4) @(negedge clk_i);
        check("sb_drain", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/paddle_key_controller.md
Name: paddle_key_controller

Overview:
- Turns the raw 4-bit board keys into the horizontal paddle position that drives `hpaddle` on `ball_absolute_top`.
- Sits beside the display pipeline in the same divided clock domain. Uses the video generator's `vsync` as its frame strobe, so the paddle moves at most once per frame.
- Provides per-key synchronisation and frame-rate debounce, direction arbitration, hold-to-accelerate speed, edge clamping, pause and re-centre.

Parameters:
- POS_WIDTH, 8: width of `hpaddle`.
- POS_MIN, 0: leftmost legal position.
- POS_MAX, 224: rightmost legal position.
- POS_INIT, 112: position after reset or re-centre.
- SPEED_WIDTH, 3: width of the `speed` output.
- SPEED_MIN, 1: initial step, in pixels per frame.
- SPEED_MAX, 4: saturating step, in pixels per frame.
- ACCEL_FRAMES, 8: consecutive move frames before speed increments.
- DEBOUNCE_FRAMES, 2: consecutive differing frame samples needed to flip a debounced key.
- Legal values: POS_MIN<=POS_INIT<=POS_MAX<2^POS_WIDTH; 1<=SPEED_MIN<=SPEED_MAX<2^SPEED_WIDTH; ACCEL_FRAMES>=1; DEBOUNCE_FRAMES>=1.

Ports:
- clk  input  1  single clock for the whole block.
- reset  input  1  asynchronous, active-low reset.
- keys  input  4  asynchronous key levels, active-high: [0] left, [1] right, [2] centre, [3] pause.
- vsync  input  1  frame strobe from the video generator; asynchronous to this block's view.
- hpaddle  output  POS_WIDTH  paddle position.
- speed  output  SPEED_WIDTH  current step size.
- moving  output  1  high while in a MOVE state.
- paused  output  1  pause flag.

Behaviour:
- Reset (reset==0, asynchronous): `hpaddle`=POS_INIT, `speed`=SPEED_MIN, `moving`=0, `paused`=0. FSM=IDLE; hold counter, debounce counters, debounced keys and all sync/edge flops are cleared.
- Synchronisation: `keys` and `vsync` each pass through a 2-flop synchroniser. `tick` = synced vsync & ~previous synced vsync, a 1-cycle pulse.
- Debounce, cycle T (`tick` high), per key i:
  - If the synced sample equals `deb[i]`: `cnt[i]`=0.
  - Otherwise `cnt[i]`++. When the count reaches DEBOUNCE_FRAMES, `deb[i]` is inverted and `cnt[i]`=0.
  - Press and release are symmetric.
- Control, cycle T+1 (registered tick, `tick_d`), acting on the updated `deb`. Outputs change at the clock edge ending T+1. Priority order:
  1. Rising edge of `deb[3]` toggles `paused`. Entering pause forces FSM=IDLE, `speed`=SPEED_MIN, hold=0, `moving`=0.
  2. While `paused`=1, nothing else acts: position is frozen and the centre and direction keys are ignored.
  3. Rising edge of `deb[2]`: `hpaddle`=POS_INIT, FSM=IDLE, `speed`=SPEED_MIN, hold=0. No movement this tick.
  4. FSM, with L=`deb[0]`&~`deb[1]` and R=`deb[1]`&~`deb[0]`:
     - IDLE: L -> MOVE_LEFT; R -> MOVE_RIGHT; none or both pressed -> stay IDLE.
     - MOVE_LEFT: L stays. R -> MOVE_RIGHT with `speed`=SPEED_MIN and hold=0. Otherwise -> IDLE with `speed`=SPEED_MIN and hold=0.
     - MOVE_RIGHT: mirror of MOVE_LEFT.
  5. Move: applied on every tick whose next state is MOVE_x, including the entry tick. The step uses the speed value held at the start of the tick (SPEED_MIN on entry or direction change).
     - Left: if `hpaddle`-`speed` < POS_MIN (computed POS_WIDTH+1 wide, no wrap), result=POS_MIN.
     - Right: if `hpaddle`+`speed` > POS_MAX, result=POS_MAX.
     - The clamped position holds while the key stays held. Acceleration continues while clamped.
  6. Acceleration, on each move tick that stays in the same direction:
     - If hold==ACCEL_FRAMES-1: `speed`=min(`speed`+1, SPEED_MAX) and hold=0.
     - Otherwise hold++.
     - The new speed is applied from the next move tick.
- `moving` = (FSM != IDLE), registered with the FSM.
- Between ticks all state holds.
- Reset asserted mid-frame or mid-debounce returns everything to reset values immediately.

Test Plan:
- Release reset with no keys, run 5 frames -> `hpaddle`=112, `speed`=1, `moving`=0, `paused`=0 throughout.
- Hold `keys[0]` from before frame 1 for 12 frames -> first move on frame 2 (debounce); frames 2-9 give 111..104 at speed 1; speed becomes 2 after frame 9; frames 10-12 give 102, 100, 98.
- 1-frame glitch on `keys[1]` (high for a single vsync sample) -> no movement and `deb[1]` never set.
- Start at 223, hold right -> 224 then 224 repeatedly; `moving`=1; speed saturates at 4 after 24 move frames and never exceeds 4.
- While moving left at speed 2, press right and release left (debounced same tick) -> direction flips, `speed`=1, next position is +1. Pressing both -> IDLE with position held.
- Pause press mid-move -> `moving`=0 and position frozen even with keys held. Centre press while paused is ignored. Second pause press, then centre press -> 112.
- Assert reset for 1 cycle mid-accelerated move -> all outputs return to reset values asynchronously.
